// File: rtl/lab3_serial_seq_detector_if.sv
// Serial-bit detector bus: stream input, count clear, and registered detector status.
interface lab3_serial_seq_detector_if #(
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
);
  logic               bit_in;
  logic               bit_valid;
  logic               clear_cnt;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic [PAT_LEN-1:0] history;
  logic               armed;

  modport master (
    output bit_in, bit_valid, clear_cnt,
    input  match, match_count, history, armed
  );

  modport slave (
    input  bit_in, bit_valid, clear_cnt,
    output match, match_count, history, armed
  );
endinterface

// File: rtl/lab3_serial_seq_detector.sv
// Overlapping serial pattern detector fed by the falling-edge DFF's Q output.
// Emits a one-cycle match pulse and keeps a saturating match count.
module lab3_serial_seq_detector #(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(4'b1101),
  parameter int unsigned        CNT_W   = 8
) (
  input logic                        clock,
  input logic                        reset,
  lab3_serial_seq_detector_if.slave  bus
);
  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {FILL, ARMED} state_t;

  state_t             state;
  logic [FILL_W-1:0]  fill_cnt;
  logic [PAT_LEN-1:0] hist;
  logic [CNT_W-1:0]   cnt;
  logic               match_q;
  logic               armed_q;

  logic [PAT_LEN-1:0] hist_next;
  logic               last_fill;
  logic               hit;

  // The PAT_LEN-th accepted bit may itself complete the first match.
  assign hist_next = {hist[PAT_LEN-2:0], bus.bit_in};
  assign last_fill = (fill_cnt == FILL_W'(PAT_LEN - 1));
  assign hit       = bus.bit_valid && (hist_next == PATTERN) &&
                     ((state == ARMED) || last_fill);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FILL;
      fill_cnt <= '0;
      hist     <= '0;
      cnt      <= '0;
      match_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      match_q <= hit;
      // A match on the same edge as a clear restarts the count at one.
      if (hit) begin
        if (bus.clear_cnt)     cnt <= CNT_W'(1);
        else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end else if (bus.clear_cnt) begin
        cnt <= '0;
      end
      if (bus.bit_valid) begin
        hist <= hist_next;
        if (state == FILL) begin
          fill_cnt <= fill_cnt + FILL_W'(1);
          if (last_fill) begin
            state   <= ARMED;
            armed_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = cnt;
  assign bus.history     = hist;
  assign bus.armed       = armed_q;
endmodule

// File: tb/tb_lab3_serial_seq_detector.sv
// Directed and randomized bench for lab3_serial_seq_detector against a queue-based reference model.
module tb_lab3_serial_seq_detector;
  logic clock;
  logic reset;
  logic bit_drv;
  logic use_dff;
  logic dff_d;
  logic dff_q;

  int checks;
  int errors;

  lab3_serial_seq_detector_if #(.PAT_LEN(4), .CNT_W(8)) bus8 ();
  lab3_serial_seq_detector_if #(.PAT_LEN(4), .CNT_W(2)) bus2 ();

  lab3_serial_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .bus(bus8)
  );
  lab3_serial_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .bus(bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Lab3 flip-flop: Q follows D on the falling edge.
  always @(negedge clock) dff_q <= dff_d;

  assign bus8.bit_in = use_dff ? dff_q : bit_drv;
  assign bus2.bit_in = use_dff ? dff_q : bit_drv;

  // Reference model: the accepted bits themselves, newest at the back.
  bit acc_q[$];
  int cnt8;
  int cnt2;
  logic exp_match;

  function automatic logic [3:0] model_hist();
    logic [3:0] h = 4'b0000;
    foreach (acc_q[i]) h = {h[2:0], acc_q[i]};
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic clr, input logic rst);
    if (use_dff) begin
      #2 dff_d = b;
    end
    @(negedge clock);
    reset          = rst;
    bit_drv        = b;
    bus8.bit_valid = v;
    bus2.bit_valid = v;
    bus8.clear_cnt = clr;
    bus2.clear_cnt = clr;
    if (rst) begin
      acc_q.delete();
      cnt8 = 0;
      cnt2 = 0;
      exp_match = 1'b0;
    end else begin
      exp_match = 1'b0;
      if (v) begin
        acc_q.push_back(b);
        if (acc_q.size() > 4) void'(acc_q.pop_front());
        exp_match = (acc_q.size() == 4) && (model_hist() == 4'b1101);
      end
      if (exp_match) begin
        cnt8 = clr ? 1 : ((cnt8 < 255) ? cnt8 + 1 : 255);
        cnt2 = clr ? 1 : ((cnt2 < 3) ? cnt2 + 1 : 3);
      end else if (clr) begin
        cnt8 = 0;
        cnt2 = 0;
      end
    end
    @(posedge clock);
    #1;
    chk("match",       32'(bus8.match),       32'(exp_match));
    chk("match_count", 32'(bus8.match_count), 32'(cnt8));
    chk("history",     32'(bus8.history),     32'(model_hist()));
    chk("armed",       32'(bus8.armed),       32'(acc_q.size() == 4));
    chk("sat_count",   32'(bus2.match_count), 32'(cnt2));
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    logic [15:0] w = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    use_dff = 1'b0;
    dff_d = 1'b0;
    bit_drv = 1'b0;
    reset = 1'b1;
    bus8.bit_valid = 1'b0;
    bus2.bit_valid = 1'b0;
    bus8.clear_cnt = 1'b0;
    bus2.clear_cnt = 1'b0;
    acc_q.delete();
    cnt8 = 0;
    cnt2 = 0;
    exp_match = 1'b0;

    // Reset state, then the first full pattern right after reset.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b1101, 4);

    // Overlapping matches.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b1101101, 7);

    // Gaps in bit_valid: only accepted bits shift.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Idle cycles hold everything.
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom), 1'b0, 1'b0);

    // Saturation on the narrow counter, then clear colliding with a match.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b1101, 4);
    for (int i = 0; i < 4; i++) feed(16'b101, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-stream discards the partial pattern.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b110, 3);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    feed(16'b101, 3);

    // Random stream through the falling-edge flip-flop.
    use_dff = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0),
           1'($urandom),
           ($urandom_range(15) == 0),
           ($urandom_range(63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
